// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator and its key sequencer:
// key codes, operator encodings, sequencer states and decoded-key record.
package calc_pkg;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_SUB = 5'h11;
  localparam logic [4:0] KEY_MUL = 5'h12;
  localparam logic [4:0] KEY_DIV = 5'h13;
  localparam logic [4:0] KEY_EQ  = 5'h14;
  localparam logic [4:0] KEY_CLR = 5'h15;

  localparam logic [2:0] FUN_ADD = 3'd0;
  localparam logic [2:0] FUN_SUB = 3'd1;
  localparam logic [2:0] FUN_MUL = 3'd2;
  localparam logic [2:0] FUN_DIV = 3'd3;

  typedef enum logic [2:0] {
    ST_ENTER_A,
    ST_ENTER_OP,
    ST_ENTER_B,
    ST_EXEC,
    ST_DONE
  } calc_state_t;

  typedef struct packed {
    logic       is_digit;
    logic       is_op;
    logic       is_eq;
    logic       is_clr;
    logic       is_illegal;
    logic [3:0] digit;
    logic [2:0] fun;
  } key_class_t;

  // Operator keys are contiguous from KEY_ADD, so the low bits are the fun code.
  function automatic logic [2:0] op_to_fun(input logic [1:0] op_sel);
    return {1'b0, op_sel};
  endfunction

endpackage

// File: rtl/calc_key_decode.sv
// Combinational classification of a 5-bit key code into digit / operator /
// equals / clear / illegal, with the digit value and operator encoding.
module calc_key_decode
  import calc_pkg::*;
(
  input  logic [4:0] key_code,
  output key_class_t key_class
);

  always_comb begin
    key_class       = '0;
    key_class.digit = key_code[3:0];
    key_class.fun   = op_to_fun(key_code[1:0]);
    if (!key_code[4]) begin
      key_class.is_digit = 1'b1;
    end else begin
      case (key_code)
        KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV: key_class.is_op = 1'b1;
        KEY_EQ:                             key_class.is_eq = 1'b1;
        KEY_CLR:                            key_class.is_clr = 1'b1;
        default:                            key_class.is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/calc_key_seq.sv
// Key sequencer for the 4-bit calculator: builds A/op/B from keys, holds them
// through a settle window, captures the result. Option: CALC_CHAIN_EN.
module calc_key_seq
  import calc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  output logic       key_ready,
  output logic [3:0] ain,
  output logic [3:0] bin,
  output logic [2:0] fun,
  input  logic [7:0] calc_out,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       err_key,
  output logic       err_div
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  calc_state_t state_q, state_d;
  logic [3:0]  ain_q, ain_d;
  logic [3:0]  bin_q, bin_d;
  logic [2:0]  fun_q, fun_d;
  logic        b_ent_q, b_ent_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        err_key_q, err_key_d;
  logic        err_div_q, err_div_d;
  key_class_t  kc;
  logic        accept;

  calc_key_decode u_decode (
    .key_code  (key_code),
    .key_class (kc)
  );

  assign key_ready = (state_q != ST_EXEC);
  assign accept    = key_valid && key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_ENTER_A;
      ain_q          <= '0;
      bin_q          <= '0;
      fun_q          <= FUN_ADD;
      b_ent_q        <= 1'b0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      err_key_q      <= 1'b0;
      err_div_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ain_q          <= ain_d;
      bin_q          <= bin_d;
      fun_q          <= fun_d;
      b_ent_q        <= b_ent_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      err_key_q      <= err_key_d;
      err_div_q      <= err_div_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ain_d          = ain_q;
    bin_d          = bin_q;
    fun_d          = fun_q;
    b_ent_d        = b_ent_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    err_key_d      = 1'b0;
    err_div_d      = err_div_q;

    if (accept && kc.is_clr) begin
      ain_d     = '0;
      bin_d     = '0;
      fun_d     = FUN_ADD;
      b_ent_d   = 1'b0;
      err_div_d = 1'b0;
      state_d   = ST_ENTER_A;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (accept) begin
            if (kc.is_digit) begin
              ain_d   = kc.digit;
              state_d = ST_ENTER_OP;
            end else begin
              err_key_d = 1'b1;
            end
          end
        end

        ST_ENTER_OP: begin
          if (accept) begin
            if (kc.is_digit) begin
              ain_d = kc.digit;
            end else if (kc.is_op) begin
              fun_d   = kc.fun;
              b_ent_d = 1'b0;
              state_d = ST_ENTER_B;
            end else begin
              err_key_d = 1'b1;
            end
          end
        end

        ST_ENTER_B: begin
          if (accept) begin
            if (kc.is_digit) begin
              bin_d   = kc.digit;
              b_ent_d = 1'b1;
            end else if (kc.is_op) begin
              fun_d = kc.fun;
            end else if (kc.is_eq && b_ent_q) begin
              cnt_d     = CNT_LOAD;
              err_div_d = 1'b0;
              state_d   = ST_EXEC;
            end else begin
              err_key_d = 1'b1;
            end
          end
        end

        ST_EXEC: begin
          if (cnt_q == '0) begin
            // Divide-by-zero never trusts the calculator's output.
            if (fun_q == FUN_DIV && bin_q == '0) begin
              result_d  = '0;
              err_div_d = 1'b1;
            end else begin
              result_d = calc_out;
            end
            result_valid_d = 1'b1;
            state_d        = ST_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end

        ST_DONE: begin
          if (accept) begin
            if (kc.is_digit) begin
              ain_d   = kc.digit;
              bin_d   = '0;
              fun_d   = FUN_ADD;
              b_ent_d = 1'b0;
              state_d = ST_ENTER_OP;
            end else if (kc.is_eq) begin
              cnt_d     = CNT_LOAD;
              err_div_d = 1'b0;
              state_d   = ST_EXEC;
            end else if (kc.is_op) begin
`ifdef CALC_CHAIN_EN
              ain_d   = result_q[3:0];
              fun_d   = kc.fun;
              b_ent_d = 1'b0;
              state_d = ST_ENTER_B;
`else
              err_key_d = 1'b1;
`endif
            end else if (kc.is_illegal) begin
              err_key_d = 1'b1;
            end
          end
        end

        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  assign ain          = ain_q;
  assign bin          = bin_q;
  assign fun          = fun_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign err_key      = err_key_q;
  assign err_div      = err_div_q;

endmodule
